// File: rtl/weather_severity_fsm_pkg.sv
// weather_pkg: shared severity/class enums and default thresholds for the weather severity unit
package weather_pkg;
  typedef enum logic [1:0] {SEV_NORMAL, SEV_CAUTION, SEV_SEVERE, SEV_EMERGENCY} severity_e;
  typedef enum logic [1:0] {CLS_CLEAR, CLS_CAUTION, CLS_SEVERE, CLS_EMERG} class_e;
  localparam int DEF_WIND_W = 6;
  localparam int DEF_TEMP_W = 8;
  localparam int DEF_WIND_CAUTION = 10;
  localparam int DEF_WIND_SEVERE = 15;
  localparam int DEF_WIND_EMERG = 20;
  localparam int DEF_TEMP_SEVERE = 35;
  localparam int DEF_TEMP_EMERG = 40;
  localparam int DEF_DEBOUNCE = 3;
endpackage

// File: rtl/weather_severity_fsm_classifier.sv
// weather_classifier: combinational per-sample severity class, highest-priority class wins
// Ports: thunderstorm, wind (unsigned), visibility (0 clear, 1/2 reduced, 3 none),
//        temperature (signed) in; cls (class_e) out.
module weather_classifier
  import weather_pkg::*;
#(
  parameter int WIND_W = DEF_WIND_W,
  parameter int TEMP_W = DEF_TEMP_W,
  parameter int WIND_CAUTION = DEF_WIND_CAUTION,
  parameter int WIND_SEVERE = DEF_WIND_SEVERE,
  parameter int WIND_EMERG = DEF_WIND_EMERG,
  parameter int TEMP_SEVERE = DEF_TEMP_SEVERE,
  parameter int TEMP_EMERG = DEF_TEMP_EMERG
) (
  input  logic                     thunderstorm,
  input  logic [WIND_W-1:0]        wind,
  input  logic [1:0]               visibility,
  input  logic signed [TEMP_W-1:0] temperature,
  output class_e                   cls
);
  localparam logic [WIND_W-1:0] W_CAU = WIND_W'(WIND_CAUTION);
  localparam logic [WIND_W-1:0] W_SEV = WIND_W'(WIND_SEVERE);
  localparam logic [WIND_W-1:0] W_EMG = WIND_W'(WIND_EMERG);
  localparam logic signed [TEMP_W-1:0] T_SEV_P = TEMP_W'(TEMP_SEVERE);
  localparam logic signed [TEMP_W-1:0] T_SEV_N = TEMP_W'(-TEMP_SEVERE);
  localparam logic signed [TEMP_W-1:0] T_EMG_P = TEMP_W'(TEMP_EMERG);
  localparam logic signed [TEMP_W-1:0] T_EMG_N = TEMP_W'(-TEMP_EMERG);
  logic w_emerg, w_severe, w_caution;
  assign w_emerg = temperature > T_EMG_P || temperature < T_EMG_N || wind > W_EMG;
  assign w_severe = thunderstorm || temperature > T_SEV_P || temperature < T_SEV_N ||
                    wind > W_SEV || visibility == 2'd3;
  assign w_caution = wind > W_CAU || visibility == 2'd1 || visibility == 2'd2;
  assign cls = w_emerg ? CLS_EMERG : w_severe ? CLS_SEVERE : w_caution ? CLS_CAUTION : CLS_CLEAR;
endmodule

// File: rtl/weather_severity_fsm.sv
// weather_severity_fsm: 4-state weather severity FSM, immediate escalation, debounced de-escalation, latched EMERGENCY
// Ports: CLK, RST (async, active-high), sample_valid + sample fields (thunderstorm, wind,
//        visibility, temperature), emerg_clear (crew acknowledge); outputs severe_weather,
//        emergency_landing_alert, ecsu_state, state_changed (all registered).
module weather_severity_fsm
  import weather_pkg::*;
#(
  parameter int WIND_W = DEF_WIND_W,
  parameter int TEMP_W = DEF_TEMP_W,
  parameter int WIND_CAUTION = DEF_WIND_CAUTION,
  parameter int WIND_SEVERE = DEF_WIND_SEVERE,
  parameter int WIND_EMERG = DEF_WIND_EMERG,
  parameter int TEMP_SEVERE = DEF_TEMP_SEVERE,
  parameter int TEMP_EMERG = DEF_TEMP_EMERG,
  parameter int DEBOUNCE = DEF_DEBOUNCE
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic                     sample_valid,
  input  logic                     thunderstorm,
  input  logic [WIND_W-1:0]        wind,
  input  logic [1:0]               visibility,
  input  logic signed [TEMP_W-1:0] temperature,
  input  logic                     emerg_clear,
  output logic                     severe_weather,
  output logic                     emergency_landing_alert,
  output logic [1:0]               ecsu_state,
  output logic                     state_changed
);
  localparam int CW = $clog2(DEBOUNCE + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE - 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE);
  class_e w_cls;
  severity_e r_state, w_next, w_imm_tgt, w_deb_tgt;
  logic w_imm, w_qual, r_severe, r_alert, r_chg;
  logic [CW-1:0] r_cnt, w_cnt;
  weather_classifier #(
    .WIND_W(WIND_W), .TEMP_W(TEMP_W), .WIND_CAUTION(WIND_CAUTION), .WIND_SEVERE(WIND_SEVERE),
    .WIND_EMERG(WIND_EMERG), .TEMP_SEVERE(TEMP_SEVERE), .TEMP_EMERG(TEMP_EMERG)
  ) u_cls (
    .thunderstorm(thunderstorm), .wind(wind), .visibility(visibility),
    .temperature(temperature), .cls(w_cls)
  );
  // w_imm/w_imm_tgt: escalations and the acknowledged EMERGENCY release; w_qual/w_deb_tgt: debounced moves
  always_comb begin
    w_imm = 1'b0;
    w_imm_tgt = r_state;
    w_qual = 1'b0;
    w_deb_tgt = r_state;
    case (r_state)
      SEV_NORMAL: begin
        w_imm = w_cls == CLS_SEVERE || w_cls == CLS_EMERG;
        w_imm_tgt = SEV_SEVERE;
        w_qual = w_cls == CLS_CAUTION;
        w_deb_tgt = SEV_CAUTION;
      end
      SEV_CAUTION: begin
        w_imm = w_cls == CLS_SEVERE || w_cls == CLS_EMERG;
        w_imm_tgt = SEV_SEVERE;
        w_qual = w_cls == CLS_CLEAR;
        w_deb_tgt = SEV_NORMAL;
      end
      SEV_SEVERE: begin
        w_imm = w_cls == CLS_EMERG;
        w_imm_tgt = SEV_EMERGENCY;
        w_qual = w_cls == CLS_CLEAR || w_cls == CLS_CAUTION;
        w_deb_tgt = SEV_CAUTION;
      end
      SEV_EMERGENCY: begin
        w_imm = emerg_clear && w_cls != CLS_EMERG;
        w_imm_tgt = SEV_SEVERE;
      end
    endcase
    w_next = !sample_valid ? r_state : w_imm ? w_imm_tgt :
             (w_qual && r_cnt == CNT_LAST) ? w_deb_tgt : r_state;
    w_cnt = !sample_valid ? r_cnt : (w_next != r_state || !w_qual) ? '0 :
            (r_cnt == CNT_MAX) ? r_cnt : r_cnt + 1'b1;
  end
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state <= SEV_NORMAL;
      r_cnt <= '0;
      r_severe <= 1'b0;
      r_alert <= 1'b0;
      r_chg <= 1'b0;
    end else begin
      r_state <= w_next;
      r_cnt <= w_cnt;
      r_severe <= w_next == SEV_SEVERE || w_next == SEV_EMERGENCY;
      r_alert <= w_next == SEV_EMERGENCY;
      r_chg <= w_next != r_state;
    end
  end
  assign ecsu_state = r_state;
  assign severe_weather = r_severe;
  assign emergency_landing_alert = r_alert;
  assign state_changed = r_chg;
endmodule

// File: tb/tb_weather_severity_fsm.sv
// tb_weather_severity_fsm: scoreboard bench for weather_severity_fsm with default parameters
module tb_weather_severity_fsm;
  typedef struct {
    logic v, ts;
    logic [5:0] w;
    logic [1:0] vis;
    logic signed [7:0] t;
    logic clr;
    logic [1:0] st;
    logic ch;
  } stim_t;
  typedef struct {
    logic [1:0] st;
    logic ch;
  } exp_t;
  logic CLK = 1'b0, RST = 1'b1;
  logic sample_valid = 1'b0, thunderstorm = 1'b0, emerg_clear = 1'b0;
  logic [5:0] wind = '0;
  logic [1:0] visibility = '0;
  logic signed [7:0] temperature = '0;
  logic severe_weather, emergency_landing_alert, state_changed;
  logic [1:0] ecsu_state;
  exp_t sb[$];
  int checks = 0, errors = 0;
  weather_severity_fsm dut (
    .CLK(CLK), .RST(RST), .sample_valid(sample_valid), .thunderstorm(thunderstorm),
    .wind(wind), .visibility(visibility), .temperature(temperature), .emerg_clear(emerg_clear),
    .severe_weather(severe_weather), .emergency_landing_alert(emergency_landing_alert),
    .ecsu_state(ecsu_state), .state_changed(state_changed)
  );
  always #5 CLK = ~CLK;
  function automatic stim_t row(logic v, logic ts, int w, int vis, int t, logic clr, int st, logic ch);
    stim_t r;
    r.v = v;
    r.ts = ts;
    r.w = 6'(w);
    r.vis = 2'(vis);
    r.t = 8'(t);
    r.clr = clr;
    r.st = 2'(st);
    r.ch = ch;
    return r;
  endfunction
  function automatic logic [4:0] exp_vec(exp_t e);
    return {e.ch, e.st == 2'd3, e.st == 2'd2 || e.st == 2'd3, e.st};
  endfunction
  task automatic drive(input stim_t r);
    exp_t e;
    @(negedge CLK);
    sample_valid = r.v;
    thunderstorm = r.ts;
    wind = r.w;
    visibility = r.vis;
    temperature = r.t;
    emerg_clear = r.clr;
    e.st = r.st;
    e.ch = r.ch;
    sb.push_back(e);
    @(posedge CLK);
    #1;
  endtask
  task automatic test_reset();
    #2;
    checks++;
    if ({state_changed, emergency_landing_alert, severe_weather, ecsu_state} !== 5'b0) begin
      errors++;
      $display("FAIL reset_async got %b required 00000",
               {state_changed, emergency_landing_alert, severe_weather, ecsu_state});
    end
    repeat (2) @(posedge CLK);
    #1;
    checks++;
    if ({state_changed, emergency_landing_alert, severe_weather, ecsu_state} !== 5'b0) begin
      errors++;
      $display("FAIL reset_held got %b required 00000",
               {state_changed, emergency_landing_alert, severe_weather, ecsu_state});
    end
    @(negedge CLK);
    RST = 1'b0;
  endtask
  task automatic test_debounce_caution();
    stim_t s[$];
    exp_t e;
    logic [4:0] ov;
    s.push_back(row(1, 0, 12, 0, 0, 0, 0, 0));
    s.push_back(row(1, 0, 12, 0, 0, 0, 0, 0));
    s.push_back(row(1, 0, 5, 0, 0, 0, 0, 0));
    s.push_back(row(1, 0, 12, 0, 0, 0, 0, 0));
    s.push_back(row(1, 0, 12, 0, 0, 0, 0, 0));
    s.push_back(row(1, 0, 12, 0, 0, 0, 1, 1));
    s.push_back(row(1, 0, 12, 0, 0, 0, 1, 0));
    s.push_back(row(1, 0, 0, 0, 0, 0, 1, 0));
    s.push_back(row(1, 0, 10, 0, 0, 0, 1, 0));
    s.push_back(row(1, 0, 0, 0, 0, 0, 0, 1));
    s.push_back(row(1, 0, 10, 0, 0, 0, 0, 0));
    s.push_back(row(1, 0, 0, 2, 0, 0, 0, 0));
    s.push_back(row(1, 0, 0, 1, 0, 0, 0, 0));
    s.push_back(row(1, 0, 11, 0, 0, 0, 1, 1));
    s.push_back(row(1, 0, 0, 0, 0, 0, 1, 0));
    s.push_back(row(1, 0, 0, 0, 0, 0, 1, 0));
    s.push_back(row(1, 0, 0, 0, 0, 0, 0, 1));
    foreach (s[i]) begin
      drive(s[i]);
      e = sb.pop_front();
      ov = {state_changed, emergency_landing_alert, severe_weather, ecsu_state};
      checks++;
      if (ov !== exp_vec(e)) begin
        errors++;
        $display("FAIL debounce[%0d] chg/alert/sev/state got %b required %b", i, ov, exp_vec(e));
      end
    end
  endtask
  task automatic test_temp_boundaries();
    stim_t s[$];
    exp_t e;
    logic [4:0] ov;
    s.push_back(row(1, 0, 0, 0, 35, 0, 0, 0));
    s.push_back(row(1, 0, 0, 0, -35, 0, 0, 0));
    s.push_back(row(1, 0, 0, 0, 36, 0, 2, 1));
    s.push_back(row(1, 0, 0, 0, -40, 0, 2, 0));
    s.push_back(row(1, 0, 0, 0, 40, 0, 2, 0));
    s.push_back(row(1, 0, 0, 0, 41, 0, 3, 1));
    foreach (s[i]) begin
      drive(s[i]);
      e = sb.pop_front();
      ov = {state_changed, emergency_landing_alert, severe_weather, ecsu_state};
      checks++;
      if (ov !== exp_vec(e)) begin
        errors++;
        $display("FAIL temp[%0d] chg/alert/sev/state got %b required %b", i, ov, exp_vec(e));
      end
    end
  endtask
  task automatic test_emerg_latch();
    stim_t s[$];
    exp_t e;
    logic [4:0] ov;
    repeat (10) s.push_back(row(1, 0, 0, 0, 0, 0, 3, 0));
    s.push_back(row(1, 0, 25, 0, 0, 1, 3, 0));
    s.push_back(row(1, 0, 5, 0, 0, 1, 2, 1));
    foreach (s[i]) begin
      drive(s[i]);
      e = sb.pop_front();
      ov = {state_changed, emergency_landing_alert, severe_weather, ecsu_state};
      checks++;
      if (ov !== exp_vec(e)) begin
        errors++;
        $display("FAIL latch[%0d] chg/alert/sev/state got %b required %b", i, ov, exp_vec(e));
      end
    end
  endtask
  task automatic test_gating_path();
    stim_t s[$];
    exp_t e;
    logic [4:0] ov;
    s.push_back(row(1, 0, 0, 0, 0, 0, 2, 0));
    s.push_back(row(1, 0, 0, 0, 0, 0, 2, 0));
    s.push_back(row(1, 0, 0, 0, 0, 0, 1, 1));
    s.push_back(row(1, 0, 0, 0, 0, 0, 1, 0));
    s.push_back(row(1, 0, 0, 0, 0, 0, 1, 0));
    s.push_back(row(1, 0, 0, 0, 0, 0, 0, 1));
    s.push_back(row(0, 1, 0, 0, 0, 0, 0, 0));
    s.push_back(row(0, 0, 30, 0, 0, 0, 0, 0));
    s.push_back(row(1, 0, 12, 0, 0, 0, 0, 0));
    s.push_back(row(1, 0, 12, 0, 0, 0, 0, 0));
    s.push_back(row(0, 0, 12, 0, 0, 0, 0, 0));
    s.push_back(row(0, 0, 0, 0, 0, 0, 0, 0));
    s.push_back(row(1, 0, 12, 0, 0, 0, 1, 1));
    foreach (s[i]) begin
      drive(s[i]);
      e = sb.pop_front();
      ov = {state_changed, emergency_landing_alert, severe_weather, ecsu_state};
      checks++;
      if (ov !== exp_vec(e)) begin
        errors++;
        $display("FAIL gating[%0d] chg/alert/sev/state got %b required %b", i, ov, exp_vec(e));
      end
    end
  endtask
  task automatic test_escalation();
    stim_t s[$];
    exp_t e;
    logic [4:0] ov;
    s.push_back(row(1, 1, 0, 0, 0, 0, 2, 1));
    s.push_back(row(1, 0, 20, 0, 0, 0, 2, 0));
    s.push_back(row(1, 0, 21, 0, 0, 0, 3, 1));
    s.push_back(row(0, 0, 0, 0, 0, 1, 3, 0));
    s.push_back(row(1, 0, 0, 0, 0, 1, 2, 1));
    s.push_back(row(1, 0, 0, 0, -41, 0, 3, 1));
    foreach (s[i]) begin
      drive(s[i]);
      e = sb.pop_front();
      ov = {state_changed, emergency_landing_alert, severe_weather, ecsu_state};
      checks++;
      if (ov !== exp_vec(e)) begin
        errors++;
        $display("FAIL escalate[%0d] chg/alert/sev/state got %b required %b", i, ov, exp_vec(e));
      end
    end
  endtask
  task automatic test_reset_mid();
    @(negedge CLK);
    sample_valid = 1'b0;
    thunderstorm = 1'b0;
    wind = '0;
    visibility = '0;
    temperature = '0;
    emerg_clear = 1'b0;
    #2 RST = 1'b1;
    #1;
    checks++;
    if ({state_changed, emergency_landing_alert, severe_weather, ecsu_state} !== 5'b0) begin
      errors++;
      $display("FAIL reset_mid got %b required 00000",
               {state_changed, emergency_landing_alert, severe_weather, ecsu_state});
    end
    @(negedge CLK);
    RST = 1'b0;
  endtask
  task automatic test_back_to_back();
    stim_t s[$];
    exp_t e;
    logic [4:0] ov;
    s.push_back(row(1, 0, 12, 0, 0, 0, 0, 0));
    s.push_back(row(1, 0, 12, 0, 0, 0, 0, 0));
    s.push_back(row(1, 0, 0, 3, 0, 0, 2, 1));
    s.push_back(row(1, 0, 0, 1, 0, 0, 2, 0));
    s.push_back(row(1, 0, 12, 0, 0, 0, 2, 0));
    s.push_back(row(1, 0, 0, 0, 0, 0, 1, 1));
    s.push_back(row(1, 0, 16, 0, 0, 0, 2, 1));
    foreach (s[i]) begin
      drive(s[i]);
      e = sb.pop_front();
      ov = {state_changed, emergency_landing_alert, severe_weather, ecsu_state};
      checks++;
      if (ov !== exp_vec(e)) begin
        errors++;
        $display("FAIL b2b[%0d] chg/alert/sev/state got %b required %b", i, ov, exp_vec(e));
      end
    end
  endtask
  initial begin
    test_reset();
    test_debounce_caution();
    test_temp_boundaries();
    test_emerg_latch();
    test_gating_path();
    test_escalation();
    test_reset_mid();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/weather_severity_fsm.md
Name: weather_severity_fsm

Overview:
- Synchronous, parametrised successor to the environmental condition state unit in the flight-safety path.
- Classifies each valid weather sample (thunderstorm, wind, visibility, signed temperature) into a severity class and drives a 4-state severity FSM.
- Escalation is immediate; de-escalation is debounced over consecutive samples. EMERGENCY is latched until crew acknowledge.
- Feeds severe_weather / emergency_landing_alert to the cockpit alert logic.

Parameters:
- WIND_W, 6, wind input width (unsigned)
- TEMP_W, 8, temperature input width (two's complement)
- WIND_CAUTION, 10, wind > this is caution
- WIND_SEVERE, 15, wind > this is severe
- WIND_EMERG, 20, wind > this is emergency
- TEMP_SEVERE, 35, |temperature| > this is severe (signed compare against +/-)
- TEMP_EMERG, 40, |temperature| > this is emergency
- DEBOUNCE, 3, consecutive qualifying valid samples required for debounced transitions (>=1)

Ports:
- CLK  input  1  system clock, rising edge
- RST  input  1  reset, asynchronous, active-high
- sample_valid  input  1  sample inputs valid this cycle
- thunderstorm  input  1  thunderstorm detected
- wind  input  WIND_W  wind speed, unsigned
- visibility  input  2  0 = clear, 1/2 = reduced, 3 = none
- temperature  input  TEMP_W  signed temperature
- emerg_clear  input  1  crew acknowledge, releases EMERGENCY latch
- severe_weather  output  1  state is SEVERE or EMERGENCY
- emergency_landing_alert  output  1  state is EMERGENCY
- ecsu_state  output  2  0 NORMAL, 1 CAUTION, 2 SEVERE, 3 EMERGENCY
- state_changed  output  1  one-cycle pulse on any state transition

Behaviour:
- Reset (async): ecsu_state = NORMAL, severe_weather = 0, emergency_landing_alert = 0, state_changed = 0, debounce counter = 0.
- Classification (combinational, per sample), priority highest first:
  - EMERG: temp > TEMP_EMERG, temp < -TEMP_EMERG, or wind > WIND_EMERG
  - SEVERE: thunderstorm, temp > TEMP_SEVERE, temp < -TEMP_SEVERE, wind > WIND_SEVERE, or visibility == 3
  - CAUTION: wind > WIND_CAUTION, or visibility in {1,2}
  - CLEAR: otherwise
  - Temperature compares are signed and boundaries are exclusive: 35 is not severe, 36 is. Wind compares are unsigned.
- FSM evaluates only when sample_valid = 1. With sample_valid = 0, state and counter hold.
- Immediate transitions (take effect on the same CLK edge as the sample; 1-cycle latency):
  - NORMAL or CAUTION -> SEVERE on class SEVERE or EMERG.
  - SEVERE -> EMERGENCY on class EMERG.
- Debounced transitions (target class seen on DEBOUNCE consecutive valid samples):
  - NORMAL -> CAUTION: class CAUTION.
  - CAUTION -> NORMAL: class CLEAR.
  - SEVERE -> CAUTION: class CAUTION or CLEAR. SEVERE never goes directly to NORMAL.
- Debounce counter:
  - Increments on a qualifying valid sample.
  - Clears on a non-qualifying valid sample and on every state change.
  - The transition fires on the sample that completes the count, i.e. counter == DEBOUNCE-1 and the current sample qualifies.
  - DEBOUNCE = 1 means immediate.
- EMERGENCY is sticky. Exit to SEVERE only when emerg_clear = 1, sample_valid = 1, and class != EMERG on the same cycle. Otherwise emerg_clear is ignored, including in all other states.
- Simultaneous immediate and debounced conditions: the immediate transition wins.
- Outputs are registered and decoded from the next state, so they are valid in the same cycle as ecsu_state.
- state_changed is high for exactly one cycle after each transition edge.
- Counter width is $clog2(DEBOUNCE+1) and saturates; there is no wrap-around.
- Reset mid-debounce: counter discarded, FSM returns to NORMAL.

Decomposition:
- Shared package weather_pkg:
  - severity_e enum (NORMAL, CAUTION, SEVERE, EMERGENCY, 2 bits)
  - class_e enum (CLEAR, CAUTION, SEVERE, EMERG)
  - default threshold localparams
- One sub-module, weather_classifier: purely combinational, parametrised thresholds, output class_e.
- FSM, debounce counter and output registers live in weather_severity_fsm.

Test Plan:
- Reset mid-operation: drive to EMERGENCY, assert RST asynchronously between edges -> all outputs 0 immediately, ecsu_state = 0.
- Debounced caution: DEBOUNCE = 3, wind = 12 for 2 valid samples -> state stays 0; 3rd sample -> ecsu_state = 1, state_changed pulses once. Insert wind = 5 after 2 samples -> counter clears, no transition.
- Immediate escalation: from NORMAL, thunderstorm = 1 on one valid sample -> next edge ecsu_state = 2, severe_weather = 1. Then temperature = -41 -> ecsu_state = 3, alert = 1.
- Temperature boundaries: temp = 35 / -35 -> class CLEAR. temp = 36 -> SEVERE. temp = 40 in SEVERE -> no EMERGENCY. temp = 41 -> EMERGENCY.
- Emergency latch: in EMERGENCY, all inputs clear for 10 samples -> state stays 3. emerg_clear = 1 with wind = 25 -> stays 3. emerg_clear = 1 with wind = 5 -> ecsu_state = 2, alert = 0.
- Sample gating and path: sample_valid = 0 with thunderstorm = 1 -> no change. SEVERE with clear inputs for 3 valid samples -> CAUTION, 3 more -> NORMAL; never 2 -> 0 directly.
